// File: rtl/soc_system_pio_echo_sequencer.sv
// Avalon-MM echo sequencer: drives tokens on out_port and times their return on in_port.
// Zero-wait-state reads; 1 + SYNC_STAGES + 1 cycles per token in loopback; no backpressure.
module soc_system_pio_echo_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  in_port,
  output logic [7:0]  out_port,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;

  logic [7:0]  sync_q [SYNC_STAGES];
  logic [7:0]  sync_in;
  logic [7:0]  seed, token;
  logic [15:0] count, done_cnt, done_cnt_inc;
  logic [31:0] timeout, lat_cnt, last_lat, min_lat, max_lat, sum_lat;
  logic [32:0] sum_ext;
  logic        irq_en, done, tmo, busy;
  logic        wr, ctrl_wr, start_req, abort_req, clr_req;
  logic        run_start, match, last_match, tmo_hit;

  assign wr           = chipselect && !write_n;
  assign ctrl_wr      = wr && (address == 3'd0);
  assign start_req    = ctrl_wr && writedata[0];
  assign abort_req    = ctrl_wr && writedata[1];
  assign clr_req      = ctrl_wr && writedata[3];
  assign busy         = (state != IDLE);
  assign sync_in      = sync_q[SYNC_STAGES-1];
  assign done_cnt_inc = done_cnt + 16'd1;
  assign sum_ext      = {1'b0, sum_lat} + {1'b0, lat_cnt};
  assign irq          = irq_en & done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Abort overrides everything; a match on the same cycle as the timeout count wins over the timeout.
  always_comb begin
    state_nxt  = state;
    run_start  = 1'b0;
    match      = 1'b0;
    last_match = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (start_req && !abort_req && count != 16'd0) begin
          run_start = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (sync_in == token && lat_cnt >= 32'(SYNC_STAGES)) begin
          match      = 1'b1;
          last_match = (done_cnt_inc == count);
          state_nxt  = last_match ? IDLE : ISSUE;
        end else if (timeout != 32'd0 && lat_cnt == timeout) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_req) begin
      state_nxt  = IDLE;
      match      = 1'b0;
      last_match = 1'b0;
      tmo_hit    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed     <= 8'h00;
      count    <= 16'd0;
      timeout  <= 32'd0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      tmo      <= 1'b0;
      token    <= 8'h00;
      out_port <= 8'h00;
      done_cnt <= 16'd0;
      lat_cnt  <= 32'd0;
      last_lat <= 32'd0;
      min_lat  <= 32'hFFFF_FFFF;
      max_lat  <= 32'd0;
      sum_lat  <= 32'd0;
    end else begin
      if (ctrl_wr) irq_en <= writedata[2];
      if (clr_req) begin
        done <= 1'b0;
        tmo  <= 1'b0;
      end
      if (wr && !busy) begin
        case (address)
          3'd1:    seed    <= writedata[7:0];
          3'd2:    count   <= writedata[15:0];
          3'd3:    timeout <= writedata;
          default: ;
        endcase
      end
      if (run_start) begin
        token    <= seed;
        done     <= 1'b0;
        tmo      <= 1'b0;
        done_cnt <= 16'd0;
        last_lat <= 32'd0;
        min_lat  <= 32'hFFFF_FFFF;
        max_lat  <= 32'd0;
        sum_lat  <= 32'd0;
      end
      if (state == ISSUE && !abort_req) begin
        out_port <= token;
        lat_cnt  <= 32'd0;
      end
      if (state == WAIT && lat_cnt != 32'hFFFF_FFFF) lat_cnt <= lat_cnt + 32'd1;
      if (match) begin
        last_lat <= lat_cnt;
        if (lat_cnt < min_lat) min_lat <= lat_cnt;
        if (lat_cnt > max_lat) max_lat <= lat_cnt;
        sum_lat  <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
        done_cnt <= done_cnt_inc;
        if (last_match) done <= 1'b1;
        else            token <= token + 8'd1;
      end
      if (tmo_hit) begin
        tmo  <= 1'b1;
        done <= 1'b1;
      end
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0: readdata = {done_cnt, 12'd0, tmo, done, busy, irq_en};
      3'd1: readdata = {24'd0, seed};
      3'd2: readdata = {16'd0, count};
      3'd3: readdata = timeout;
      3'd4: readdata = last_lat;
      3'd5: readdata = min_lat;
      3'd6: readdata = max_lat;
      3'd7: readdata = sum_lat;
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_pio_echo_sequencer.sv
// Directed bench for the echo sequencer: loopback, delayed echo, timeout, abort, ignored starts, reset.
module tb_soc_system_pio_echo_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0] tq[$];

  // Echo source: 0 = loopback, 1 = delayed copy of out_port, 2 = constant.
  int         mode = 0;
  logic [7:0] const_val = 8'h55;
  logic [7:0] dly [16];
  int         d;

  always #5 clk = ~clk;

  soc_system_pio_echo_sequencer #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  always @(posedge clk) begin
    dly[0] <= out_port;
    for (int i = 1; i < 16; i++) dly[i] <= dly[i-1];
  end

  // Per-token extra echo delay: 5 cycles for 0x40, 9 for 0x41, 3 otherwise.
  always_comb begin
    d = (out_port == 8'h40) ? 5 : (out_port == 8'h41) ? 9 : 3;
    case (mode)
      0:       in_port = out_port;
      1:       in_port = dly[d-1];
      default: in_port = const_val;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] dat);
    @(negedge clk);
    address = a; writedata = dat; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Counts negedges until busy drops, logging each new out_port value.
  task automatic wait_run(output int cyc);
    logic [7:0] prev;
    tq.delete();
    prev = out_port;
    cyc = 0;
    address = 3'd0;
    #1;
    while (readdata[1] && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (out_port != prev) begin
        tq.push_back(out_port);
        prev = out_port;
      end
    end
    chk("run_finished_busy", {31'd0, readdata[1]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dly[i] = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_port", {24'd0, out_port}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rchk("rst_status", 3'd0, 32'h0);
    rchk("rst_last", 3'd4, 32'h0);
    rchk("rst_min", 3'd5, 32'hFFFF_FFFF);
    rchk("rst_sum", 3'd7, 32'h0);
    reset_n = 1'b1;

    // Loopback, three tokens from 0x10
    mode = 0;
    wr(3'd1, 32'h10); wr(3'd2, 32'd3); wr(3'd3, 32'd0); wr(3'd0, 32'h1);
    wait_run(n);
    chk("lb_cycles", n, 32'd12);
    chk("lb_ntok", tq.size(), 32'd3);
    if (tq.size() == 3) begin
      chk("lb_tok0", {24'd0, tq[0]}, 32'h10);
      chk("lb_tok1", {24'd0, tq[1]}, 32'h11);
      chk("lb_tok2", {24'd0, tq[2]}, 32'h12);
    end
    rchk("lb_last", 3'd4, 32'd2);
    rchk("lb_min", 3'd5, 32'd2);
    rchk("lb_max", 3'd6, 32'd2);
    rchk("lb_sum", 3'd7, 32'd6);
    rchk("lb_status", 3'd0, 32'h0003_0004);
    chk("lb_irq_off", {31'd0, irq}, 32'h0);

    // Token wrap 0xFE -> 0x00 with irq enabled
    wr(3'd1, 32'hFE); wr(3'd0, 32'h5);
    wait_run(n);
    chk("wrap_ntok", tq.size(), 32'd3);
    if (tq.size() == 3) begin
      chk("wrap_tok0", {24'd0, tq[0]}, 32'hFE);
      chk("wrap_tok1", {24'd0, tq[1]}, 32'hFF);
      chk("wrap_tok2", {24'd0, tq[2]}, 32'h00);
    end
    rchk("wrap_status", 3'd0, 32'h0003_0005);
    chk("wrap_irq", {31'd0, irq}, 32'h1);
    wr(3'd0, 32'hC);
    rchk("clear_status", 3'd0, 32'h0003_0001);
    chk("clear_irq", {31'd0, irq}, 32'h0);

    // Timeout: echo stuck at 0x55, fires at lat_cnt == 20
    mode = 2;
    wr(3'd1, 32'h00); wr(3'd3, 32'd20); wr(3'd0, 32'h5);
    wait_run(n);
    chk("tmo_cycles", n, 32'd22);
    rchk("tmo_status", 3'd0, 32'h0000_000D);
    rchk("tmo_min", 3'd5, 32'hFFFF_FFFF);
    rchk("tmo_last", 3'd4, 32'h0);
    chk("tmo_irq", {31'd0, irq}, 32'h1);

    // Delayed echo: latencies 7, 11, 5
    mode = 1;
    wr(3'd3, 32'd0); wr(3'd1, 32'h40); wr(3'd0, 32'h5);
    wait_run(n);
    chk("dly_cycles", n, 32'd29);
    rchk("dly_last", 3'd4, 32'd5);
    rchk("dly_min", 3'd5, 32'd5);
    rchk("dly_max", 3'd6, 32'd11);
    rchk("dly_sum", 3'd7, 32'd23);
    rchk("dly_status", 3'd0, 32'h0003_0005);

    // Abort during WAIT of the second exchange
    wr(3'd0, 32'h5);
    repeat (14) @(negedge clk);
    wr(3'd0, 32'h6);
    rchk("abort_status", 3'd0, 32'h0001_0001);
    chk("abort_out_port", {24'd0, out_port}, 32'h41);
    rchk("abort_last", 3'd4, 32'd7);
    wr(3'd2, 32'd7);
    rchk("abort_count_wr", 3'd2, 32'd7);

    // Start with COUNT=0 does nothing
    mode = 0;
    wr(3'd2, 32'd0); wr(3'd0, 32'h5);
    rchk("cnt0_status", 3'd0, 32'h0001_0001);

    // Start and SEED write while busy are ignored
    wr(3'd2, 32'd2); wr(3'd1, 32'h20); wr(3'd0, 32'h5);
    wr(3'd0, 32'h5); wr(3'd1, 32'h99);
    wait_run(n);
    chk("busy_cycles", n, 32'd4);
    rchk("busy_seed", 3'd1, 32'h20);
    rchk("busy_status", 3'd0, 32'h0002_0005);
    chk("busy_out_port", {24'd0, out_port}, 32'h21);

    // Start+abort together: no run
    wr(3'd0, 32'h7);
    rchk("stab_status", 3'd0, 32'h0002_0005);

    // Reset mid-run
    wr(3'd2, 32'd3); wr(3'd1, 32'h30); wr(3'd0, 32'h1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_out_port", {24'd0, out_port}, 32'h0);
    chk("mrst_irq", {31'd0, irq}, 32'h0);
    rchk("mrst_status", 3'd0, 32'h0);
    rchk("mrst_seed", 3'd1, 32'h0);
    rchk("mrst_count", 3'd2, 32'h0);
    rchk("mrst_last", 3'd4, 32'h0);
    rchk("mrst_min", 3'd5, 32'hFFFF_FFFF);
    rchk("mrst_sum", 3'd7, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
